// File: rtl/fcore_pkg.sv
// Shared types for the fcore ALU issue slice: opcodes and issue FSM states.
package fcore_pkg;

  localparam int OPC_W = 5;

  typedef enum logic [OPC_W-1:0] {
    OP_NOP  = 5'd0,
    OP_ADD  = 5'd1,
    OP_SUB  = 5'd2,
    OP_AND  = 5'd3,
    OP_OR   = 5'd4,
    OP_XOR  = 5'd5,
    OP_SLL  = 5'd6,
    OP_SRL  = 5'd7,
    OP_SRA  = 5'd8,
    OP_SLT  = 5'd9,
    OP_SLTU = 5'd10,
    OP_MUL  = 5'd11,
    OP_DIV  = 5'd12,
    OP_BEQ  = 5'd13,
    OP_BLT  = 5'd14,
    OP_BNE  = 5'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READ  = 2'd1,
    S_EXEC  = 2'd2,
    S_STALL = 2'd3
  } issue_state_e;

endpackage

// File: rtl/fcore_regfile.sv
// Register file: two operand read ports, one debug port, one write port
// where the ALU writeback has priority over the external preload.
import fcore_pkg::*;

module fcore_regfile #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  output logic [DATA_WIDTH-1:0] rd_data_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  output logic [DATA_WIDTH-1:0] rd_data_b,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0] dbg_data,
  input  logic                  alu_wr_en,
  input  logic [ADDR_WIDTH-1:0] alu_wr_addr,
  input  logic [DATA_WIDTH-1:0] alu_wr_data,
  input  logic                  ext_wr_en,
  input  logic [ADDR_WIDTH-1:0] ext_wr_addr,
  input  logic [DATA_WIDTH-1:0] ext_wr_data
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regs [DEPTH];
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  always_comb begin
    wr_en   = alu_wr_en || ext_wr_en;
    wr_addr = alu_wr_en ? alu_wr_addr : ext_wr_addr;
    wr_data = alu_wr_en ? alu_wr_data : ext_wr_data;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wr_en) begin
      regs[wr_addr] <= wr_data;
    end
  end

  assign rd_data_a = regs[rd_addr_a];
  assign rd_data_b = regs[rd_addr_b];
  assign dbg_data  = regs[dbg_addr];

endmodule

// File: rtl/fcore_alu_issue.sv
// ALU issue stage: accept, read operands, fire a one-cycle exec strobe.
// Define FCORE_FORWARDING_EN to bypass writeback data into READ.
import fcore_pkg::*;

module fcore_alu_issue #(
  parameter int OPCODE_WIDTH   = 5,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      instr_valid,
  output logic                      instr_ready,
  input  logic [OPCODE_WIDTH-1:0]   instr_opcode,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_a,
  input  logic [REG_ADDR_WIDTH-1:0] instr_src_b,
  input  logic [REG_ADDR_WIDTH-1:0] instr_dest,
  output logic [DATA_WIDTH-1:0]     alu_op_a,
  output logic [DATA_WIDTH-1:0]     alu_op_b,
  output logic [OPCODE_WIDTH-1:0]   alu_opcode,
  output logic [REG_ADDR_WIDTH-1:0] alu_dest,
  output logic                      alu_exec,
  input  logic [2*DATA_WIDTH-1:0]   alu_result,
  input  logic [REG_ADDR_WIDTH-1:0] alu_dest_in,
  input  logic                      alu_result_valid,
  input  logic                      alu_core_stall,
  input  logic                      ext_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] ext_wr_addr,
  input  logic [DATA_WIDTH-1:0]     ext_wr_data,
  output logic                      ext_wr_ready,
  input  logic [REG_ADDR_WIDTH-1:0] dbg_addr,
  output logic [DATA_WIDTH-1:0]     dbg_data
);

  issue_state_e              state;
  logic [REG_ADDR_WIDTH-1:0] src_a;
  logic [REG_ADDR_WIDTH-1:0] src_b;
  logic [DATA_WIDTH-1:0]     rf_a;
  logic [DATA_WIDTH-1:0]     rf_b;
  logic [DATA_WIDTH-1:0]     wb_data;
  logic [DATA_WIDTH-1:0]     opnd_a;
  logic [DATA_WIDTH-1:0]     opnd_b;
  logic                      haz_a;
  logic                      haz_b;
  logic                      read_hold;
  logic                      accept;
  logic                      unused_hi;

  assign wb_data   = alu_result[DATA_WIDTH-1:0];
  assign unused_hi = ^alu_result[2*DATA_WIDTH-1:DATA_WIDTH];

  assign ext_wr_ready = !alu_result_valid;

  assign instr_ready = !reset &&
    ((state == S_IDLE) ||
     ((state == S_EXEC) && !alu_core_stall));

  assign accept = instr_valid && instr_ready;

  assign haz_a = alu_result_valid && (alu_dest_in == src_a);
  assign haz_b = alu_result_valid && (alu_dest_in == src_b);

`ifdef FCORE_FORWARDING_EN
  assign opnd_a    = haz_a ? wb_data : rf_a;
  assign opnd_b    = haz_b ? wb_data : rf_b;
  assign read_hold = 1'b0;
`else
  // Stale operand this cycle; wait for the write to land.
  assign opnd_a    = rf_a;
  assign opnd_b    = rf_b;
  assign read_hold = haz_a || haz_b;
`endif

  fcore_regfile #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (REG_ADDR_WIDTH)
  ) u_regfile (
    .clock       (clock),
    .reset       (reset),
    .rd_addr_a   (src_a),
    .rd_data_a   (rf_a),
    .rd_addr_b   (src_b),
    .rd_data_b   (rf_b),
    .dbg_addr    (dbg_addr),
    .dbg_data    (dbg_data),
    .alu_wr_en   (alu_result_valid),
    .alu_wr_addr (alu_dest_in),
    .alu_wr_data (wb_data),
    .ext_wr_en   (ext_wr_en && ext_wr_ready),
    .ext_wr_addr (ext_wr_addr),
    .ext_wr_data (ext_wr_data)
  );

  // alu_dest/alu_opcode load at accept so they hold through READ and EXEC.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= S_IDLE;
      src_a      <= '0;
      src_b      <= '0;
      alu_op_a   <= '0;
      alu_op_b   <= '0;
      alu_opcode <= '0;
      alu_dest   <= '0;
      alu_exec   <= 1'b0;
    end else begin
      alu_exec <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            src_a      <= instr_src_a;
            src_b      <= instr_src_b;
            alu_opcode <= instr_opcode;
            alu_dest   <= instr_dest;
            state      <= S_READ;
          end
        end
        S_READ: begin
          if (!read_hold) begin
            alu_op_a <= opnd_a;
            alu_op_b <= opnd_b;
            alu_exec <= 1'b1;
            state    <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (alu_core_stall) begin
            state <= S_STALL;
          end else if (accept) begin
            src_a      <= instr_src_a;
            src_b      <= instr_src_b;
            alu_opcode <= instr_opcode;
            alu_dest   <= instr_dest;
            state      <= S_READ;
          end else begin
            state <= S_IDLE;
          end
        end
        S_STALL: begin
          if (alu_result_valid) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcore_alu_issue.sv
// Directed bench for fcore_alu_issue: preload, issue, hazards, stall,
// write collision, wide result and mid-EXEC reset.
module tb_fcore_alu_issue;

  localparam int OW = 5;
  localparam int DW = 32;
  localparam int AW = 4;

  logic          clock;
  logic          reset;
  logic          instr_valid;
  logic          instr_ready;
  logic [OW-1:0] instr_opcode;
  logic [AW-1:0] instr_src_a;
  logic [AW-1:0] instr_src_b;
  logic [AW-1:0] instr_dest;
  logic [DW-1:0] alu_op_a;
  logic [DW-1:0] alu_op_b;
  logic [OW-1:0] alu_opcode;
  logic [AW-1:0] alu_dest;
  logic          alu_exec;
  logic [2*DW-1:0] alu_result;
  logic [AW-1:0] alu_dest_in;
  logic          alu_result_valid;
  logic          alu_core_stall;
  logic          ext_wr_en;
  logic [AW-1:0] ext_wr_addr;
  logic [DW-1:0] ext_wr_data;
  logic          ext_wr_ready;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  int checks = 0;
  int failures = 0;

  fcore_alu_issue #(
    .OPCODE_WIDTH   (OW),
    .DATA_WIDTH     (DW),
    .REG_ADDR_WIDTH (AW)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .instr_valid      (instr_valid),
    .instr_ready      (instr_ready),
    .instr_opcode     (instr_opcode),
    .instr_src_a      (instr_src_a),
    .instr_src_b      (instr_src_b),
    .instr_dest       (instr_dest),
    .alu_op_a         (alu_op_a),
    .alu_op_b         (alu_op_b),
    .alu_opcode       (alu_opcode),
    .alu_dest         (alu_dest),
    .alu_exec         (alu_exec),
    .alu_result       (alu_result),
    .alu_dest_in      (alu_dest_in),
    .alu_result_valid (alu_result_valid),
    .alu_core_stall   (alu_core_stall),
    .ext_wr_en        (ext_wr_en),
    .ext_wr_addr      (ext_wr_addr),
    .ext_wr_data      (ext_wr_data),
    .ext_wr_ready     (ext_wr_ready),
    .dbg_addr         (dbg_addr),
    .dbg_data         (dbg_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag,
                       input logic [63:0] obs,
                       input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic peek(input logic [AW-1:0] a,
                      input string tag,
                      input logic [63:0] exp);
    dbg_addr = a;
    #1;
    check(tag, dbg_data, exp);
  endtask

  task automatic ext_write(input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
    ext_wr_en   = 1'b1;
    ext_wr_addr = a;
    ext_wr_data = d;
    tick();
    ext_wr_en   = 1'b0;
  endtask

  task automatic offer(input logic [OW-1:0] op,
                       input logic [AW-1:0] sa,
                       input logic [AW-1:0] sb,
                       input logic [AW-1:0] d);
    instr_valid  = 1'b1;
    instr_opcode = op;
    instr_src_a  = sa;
    instr_src_b  = sb;
    instr_dest   = d;
  endtask

  task automatic wb(input logic [AW-1:0] d,
                    input logic [63:0] r);
    alu_result_valid = 1'b1;
    alu_dest_in      = d;
    alu_result       = r;
  endtask

  initial begin
    reset            = 1'b1;
    instr_valid      = 1'b0;
    instr_opcode     = '0;
    instr_src_a      = '0;
    instr_src_b      = '0;
    instr_dest       = '0;
    alu_result       = '0;
    alu_dest_in      = '0;
    alu_result_valid = 1'b0;
    alu_core_stall   = 1'b0;
    ext_wr_en        = 1'b0;
    ext_wr_addr      = '0;
    ext_wr_data      = '0;
    dbg_addr         = '0;

    // Reset state
    @(negedge clock);
    @(negedge clock);
    check("rst_ready", instr_ready, 0);
    check("rst_exec", alu_exec, 0);
    check("rst_op_a", alu_op_a, 0);
    check("rst_dest", alu_dest, 0);
    reset = 1'b0;
    #1;
    check("rel_ready", instr_ready, 1);

    // Preload
    check("ext_ready_idle", ext_wr_ready, 1);
    ext_write(4'd1, 32'd5);
    ext_write(4'd2, 32'd3);
    peek(4'd1, "pre_r1", 5);
    peek(4'd2, "pre_r2", 3);

    // ADD r3 = r1 + r2
    offer(5'd1, 4'd1, 4'd2, 4'd3);
    tick();
    instr_valid = 1'b0;
    #1;
    check("read_ready", instr_ready, 0);
    check("read_exec", alu_exec, 0);
    check("read_dest", alu_dest, 3);
    tick();
    check("add_exec", alu_exec, 1);
    check("add_op_a", alu_op_a, 5);
    check("add_op_b", alu_op_b, 3);
    check("add_opc", alu_opcode, 1);
    check("add_dest", alu_dest, 3);
    check("exec_ready", instr_ready, 1);
    tick();
    check("exec_pulse", alu_exec, 0);
    wb(4'd3, 64'd8);
    #1;
    check("wb_ext_ready", ext_wr_ready, 0);
    tick();
    alu_result_valid = 1'b0;
    peek(4'd3, "add_r3", 8);

    // Back-to-back ADD then SUB with RAW on r3
    ext_write(4'd3, 32'd0);
    peek(4'd3, "clr_r3", 0);
    offer(5'd1, 4'd1, 4'd2, 4'd3);
    tick();
    instr_valid = 1'b0;
    tick();
    check("b2b_exec1", alu_exec, 1);
    check("b2b_op_a1", alu_op_a, 5);
    offer(5'd2, 4'd3, 4'd1, 4'd4);
    #1;
    check("b2b_ready", instr_ready, 1);
    tick();
    instr_valid = 1'b0;
    wb(4'd3, 64'd8);
    tick();
    alu_result_valid = 1'b0;
`ifdef FCORE_FORWARDING_EN
    check("fwd_exec", alu_exec, 1);
`else
    check("bub_exec", alu_exec, 0);
    check("bub_ready", instr_ready, 0);
    tick();
    check("bub_exec2", alu_exec, 1);
`endif
    check("sub_op_a", alu_op_a, 8);
    check("sub_op_b", alu_op_b, 5);
    check("sub_opc", alu_opcode, 2);
    check("sub_dest", alu_dest, 4);
    tick();
    check("sub_idle", instr_ready, 1);

    // Stall in EXEC
    offer(5'd1, 4'd1, 4'd2, 4'd6);
    tick();
    instr_valid = 1'b0;
    tick();
    check("stl_exec", alu_exec, 1);
    alu_core_stall = 1'b1;
    #1;
    check("stl_ready_exec", instr_ready, 0);
    tick();
    alu_core_stall = 1'b0;
    #1;
    check("stl_ready1", instr_ready, 0);
    check("stl_exec0", alu_exec, 0);
    tick();
    check("stl_ready2", instr_ready, 0);
    wb(4'd6, 64'd8);
    tick();
    alu_result_valid = 1'b0;
    #1;
    check("stl_idle", instr_ready, 1);
    peek(4'd6, "stl_r6", 8);

    // Writeback vs external write collision
    wb(4'd7, 64'h11);
    ext_wr_en   = 1'b1;
    ext_wr_addr = 4'd5;
    ext_wr_data = 32'hAA;
    #1;
    check("col_ready", ext_wr_ready, 0);
    tick();
    alu_result_valid = 1'b0;
    peek(4'd5, "col_r5", 0);
    peek(4'd7, "col_r7", 32'h11);
    check("retry_ready", ext_wr_ready, 1);
    tick();
    ext_wr_en = 1'b0;
    peek(4'd5, "retry_r5", 32'hAA);

    // Wide result truncation
    wb(4'd8, 64'hFFFF_FFFF_0000_0007);
    tick();
    alu_result_valid = 1'b0;
    peek(4'd8, "wide_r8", 7);

    // Reset mid-EXEC
    offer(5'd1, 4'd1, 4'd2, 4'd9);
    tick();
    instr_valid = 1'b0;
    tick();
    check("mid_exec", alu_exec, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_exec", alu_exec, 0);
    check("mid_rst_op_a", alu_op_a, 0);
    check("mid_rst_op_b", alu_op_b, 0);
    check("mid_rst_opc", alu_opcode, 0);
    check("mid_rst_dest", alu_dest, 0);
    check("mid_rst_ready", instr_ready, 0);
    peek(4'd1, "mid_rst_r1", 0);
    tick();
    reset = 1'b0;
    #1;
    check("mid_rel_ready", instr_ready, 1);
    wb(4'd9, 64'h42);
    tick();
    alu_result_valid = 1'b0;
    check("mid_rel_exec", alu_exec, 0);
    peek(4'd9, "late_wb_r9", 32'h42);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fcore_alu_issue.md
FCORE_ALU_ISSUE -- requirements
Module: fcore_alu_issue

Interface
REQ-001 SHALL have parameter OPCODE_WIDTH, default 5: width of the ALU opcode field.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: register and operand width.
REQ-003 SHALL have parameter REG_ADDR_WIDTH, default 4: register address width; register file has 2**REG_ADDR_WIDTH entries.
REQ-004 SHALL have ports, one per line (name, direction, width, meaning):
- clock, in, 1: single clock; all logic on its rising edge.
- reset, in, 1: asynchronous, active-high reset.
- instr_valid, in, 1: instruction offered.
- instr_ready, out, 1: instruction accepted when high with instr_valid.
- instr_opcode, in, OPCODE_WIDTH: ALU opcode.
- instr_src_a / instr_src_b, in, REG_ADDR_WIDTH: source registers.
- instr_dest, in, REG_ADDR_WIDTH: destination register.
- alu_op_a / alu_op_b, out, DATA_WIDTH: operands to ALU.
- alu_opcode, out, OPCODE_WIDTH: opcode to ALU.
- alu_dest, out, REG_ADDR_WIDTH: destination to ALU.
- alu_exec, out, 1: one-cycle execute strobe.
- alu_result, in, 2*DATA_WIDTH: ALU result; only bits DATA_WIDTH-1:0 are written back.
- alu_dest_in, in, REG_ADDR_WIDTH: result destination from ALU.
- alu_result_valid, in, 1: result strobe.
- alu_core_stall, in, 1: ALU multi-cycle stall.
- ext_wr_en, in, 1; ext_wr_addr, in, REG_ADDR_WIDTH; ext_wr_data, in, DATA_WIDTH: external register preload.
- ext_wr_ready, out, 1: external write accepted.
- dbg_addr, in, REG_ADDR_WIDTH; dbg_data, out, DATA_WIDTH: combinational register read.

Function
REQ-005 SHALL implement FSM IDLE, READ, EXEC, STALL; reset state IDLE.
REQ-006 instr_ready SHALL be high in IDLE and EXEC (unless alu_core_stall is high), low in READ and STALL; accept captures opcode/src/dest, next state READ.
REQ-007 READ: drive alu_dest=captured dest; register operands from register file into alu_op_a/alu_op_b; next EXEC.
REQ-008 alu_dest SHALL be stable from the READ cycle through the EXEC cycle, since the ALU samples the destination one cycle before alu_exec.
REQ-009 EXEC: alu_exec=1 for exactly one cycle; alu_opcode valid; next READ if a new instruction is accepted, else IDLE; if alu_core_stall is high, next STALL.
REQ-010 STALL: alu_exec=0, no accept; on alu_result_valid go to IDLE.
REQ-011 Writeback: when alu_result_valid=1, write alu_result[DATA_WIDTH-1:0] into register alu_dest_in at that clock edge.
REQ-012 ext_wr_ready SHALL equal !alu_result_valid; an external write occurs only when ext_wr_en && ext_wr_ready, so the ALU writeback always wins a collision.
REQ-013 Throughput: one instruction per 2 cycles; alu_exec rises 2 cycles after accept.
REQ-014 Hazard: a READ that coincides with a writeback to a matching src register is a RAW hazard; handling is per REQ-019/020.
REQ-015 dbg_data SHALL reflect the register contents combinationally; a write becomes visible the cycle after.

Reset
REQ-016 Reset SHALL clear all registers, register-file contents, state (to IDLE), alu_exec, alu_op_a/b, alu_opcode and alu_dest to 0.
REQ-017 instr_ready SHALL be 0 while reset is asserted and 1 in the first cycle after release.
REQ-018 Reset during EXEC or STALL SHALL abandon the instruction; a later alu_result_valid SHALL still be written back.

Configuration
REQ-019 With FCORE_FORWARDING_EN defined, READ SHALL bypass alu_result[DATA_WIDTH-1:0] to each operand whose src equals alu_dest_in while alu_result_valid=1; no bubble.
REQ-020 Without FCORE_FORWARDING_EN, a hazard SHALL hold READ for one extra cycle (alu_exec delayed 1 cycle), then read the updated register.

Structure
REQ-021 Shared package fcore_pkg SHALL hold the opcode enum (ADD=1 ... BNE=15) and the issue FSM state enum.
REQ-022 The register file SHALL be sub-module fcore_regfile: 2 combinational read ports, 1 debug read port, 1 write port with an ALU/external mux.

Verification
REQ-023 Preload r1=5, r2=3; issue ADD r3=r1+r2 -> alu_exec at accept+2 with op_a=5, op_b=3; after ALU returns 8, dbg_addr=3 gives 8.
REQ-024 Back-to-back ADD r3=r1+r2 then SUB r4=r3-r1, forwarding on -> second op_a=8, no bubble; forwarding off -> one bubble, op_a=8.
REQ-025 alu_core_stall pulsed in EXEC -> FSM in STALL, instr_ready=0 until alu_result_valid, then IDLE.
REQ-026 ext_wr_en to r5 in the same cycle as alu_result_valid -> ext_wr_ready=0, r5 unchanged by ext; retry next cycle -> written.
REQ-027 Reset asserted mid-EXEC -> all outputs 0 immediately, registers 0, instr_ready=1 the cycle after release.
REQ-028 alu_result=0xFFFF_FFFF_0000_0007 -> the destination register holds 0x0000_0007.
